// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Access-size encodings and FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word
// and sign- or zero-extends it for writeback.
module load_extend
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [1:0]           byte_sel,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] rdata,
  output logic [WORD_SIZE-1:0] ext_data
);

  logic [WORD_SIZE-1:0] lane;

  always_comb begin
    lane     = rdata >> {byte_sel, 3'b000};
    ext_data = lane;
    case (funct3)
      F3_B:  ext_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:  ext_data = {{16{lane[15]}}, lane[15:0]};
      F3_BU: ext_data = {24'd0, lane[7:0]};
      F3_HU: ext_data = {16'd0, lane[15:0]};
      default: ext_data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one data-bus transaction
// per load/store, stalling the pipeline until it completes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH   = WORD_SIZE / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_SIZE-1:0]  store_data,
  output logic                  stall,
  output logic [WORD_SIZE-1:0]  memory_data,
  output logic                  access_fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [BE_WIDTH-1:0]   bus_be,
  output logic [WORD_SIZE-1:0]  bus_wdata,
  input  logic                  bus_ready,
  input  logic                  bus_rvalid,
  input  logic [WORD_SIZE-1:0]  bus_rdata
);

  lsu_state_t state, state_n;

  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [2:0]            cap_f3;
  logic                  cap_we;
  logic [BE_WIDTH-1:0]   cap_be;
  logic [WORD_SIZE-1:0]  cap_wdata;
  logic                  cap_fault;
  logic [WORD_SIZE-1:0]  mem_data_q;

  logic                  req;
  logic                  start;
  logic                  bad_f3;
  logic                  misalign;
  logic                  illegal;
  logic                  load_done;
  logic [BE_WIDTH-1:0]   be_n;
  logic [WORD_SIZE-1:0]  wdata_n;
  logic [WORD_SIZE-1:0]  ext_data;

  assign req     = mem_read | mem_write;
  assign illegal = bad_f3 | misalign;
  assign start   = (state == IDLE) & req;

  always_comb begin
    bad_f3   = 1'b0;
    misalign = 1'b0;
    case (funct3)
      F3_B:  bad_f3 = 1'b0;
      F3_H:  misalign = addr[0];
      F3_W:  misalign = |addr[1:0];
      F3_BU: bad_f3 = mem_write;
      F3_HU: begin
        bad_f3   = mem_write;
        misalign = addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the enables alone pick bytes.
  always_comb begin
    be_n    = '1;
    wdata_n = store_data;
    if (mem_write) begin
      case (funct3)
        F3_B: begin
          be_n    = BE_WIDTH'(4'b0001) << addr[1:0];
          wdata_n = {4{store_data[7:0]}};
        end
        F3_H: begin
          be_n    = BE_WIDTH'(4'b0011) << addr[1:0];
          wdata_n = {2{store_data[15:0]}};
        end
        default: be_n = '1;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    load_done = 1'b0;
    case (state)
      IDLE: if (req) state_n = illegal ? DONE : REQ;
      REQ: begin
        if (bus_ready) begin
          if (cap_we) begin
            state_n = DONE;
          end else if (bus_rvalid) begin
            state_n   = DONE;
            load_done = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          state_n   = DONE;
          load_done = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_addr   <= '0;
      cap_f3     <= '0;
      cap_we     <= 1'b0;
      cap_be     <= '0;
      cap_wdata  <= '0;
      cap_fault  <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        cap_fault <= illegal;
        if (!illegal) begin
          cap_addr  <= addr;
          cap_f3    <= funct3;
          cap_we    <= mem_write;
          cap_be    <= be_n;
          cap_wdata <= wdata_n;
        end
      end
      if (load_done) mem_data_q <= ext_data;
    end
  end

  load_extend #(
    .WORD_SIZE(WORD_SIZE)
  ) u_load_extend (
    .byte_sel(cap_addr[1:0]),
    .funct3  (cap_f3),
    .rdata   (bus_rdata),
    .ext_data(ext_data)
  );

  assign stall        = start | (state == REQ) | (state == WAIT);
  assign access_fault = (state == DONE) & cap_fault;
  assign memory_data  = mem_data_q;
  assign bus_req      = (state == REQ);
  assign bus_we       = cap_we;
  assign bus_addr     = {cap_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus_be       = cap_be;
  assign bus_wdata    = cap_wdata;

endmodule
